// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame sequencer: state encoding, HD44780
// command bytes and small character helpers.
// Optional feature macro: LCD_REFRESH_ON_CHANGE_EN adds the IDLE state.
package lcd_pkg;

`ifdef LCD_REFRESH_ON_CHANGE_EN
    typedef enum logic [2:0] {
        INIT, LATCH, ISSUE, WAIT, SETTLE, ADVANCE, IDLE
    } lcd_state_t;
`else
    typedef enum logic [2:0] {
        INIT, LATCH, ISSUE, WAIT, SETTLE, ADVANCE
    } lcd_state_t;
`endif

    localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CMD_CLR   = 8'h01;  // clear display
    localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;  // set DDRAM address
    localparam logic [7:0] LCD_ROW1_BASE = 8'h40;  // DDRAM address of row 1

    // Nibble to ASCII hex digit, for blocks that format numbers upstream.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Anything the LCD font cannot show is replaced by a space.
    function automatic logic [7:0] lcd_printable(input logic [7:0] b);
        return ((b < 8'h20) || (b > 8'h7E)) ? 8'h20 : b;
    endfunction

endpackage

// File: rtl/lcd_settle_timer.sv
// Settle-delay counter used after every accepted LCD transfer.
// Counts while 'count' is high; 'expired' flags the last settle cycle;
// 'load' zeroes the counter and has priority over counting.
module lcd_settle_timer
    import lcd_pkg::*;
#(
    parameter int DLY_CYCLES = 262142
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int CW = $clog2(DLY_CYCLES + 1);

    logic [CW-1:0] cnt_reg;

    // Settle counter: cleared by reset or load, advanced while counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (count) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Independent of 'count' so the caller's next-state logic has no loop.
    assign expired = (cnt_reg == CW'(DLY_CYCLES - 1));

endmodule

// File: rtl/lcd_frame_seq.sv
// LCD frame sequencer: runs the controller init commands once after reset,
// then repeatedly snapshots iCHARS and streams it row by row (row address
// command followed by the row's characters) to an LCD byte-transfer engine.
// Optional feature macro: LCD_REFRESH_ON_CHANGE_EN -- park in IDLE after a
// frame and redraw only when iCHARS differs from the last snapshot.
module lcd_frame_seq
    import lcd_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int DLY_CYCLES = 262142
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [ROWS*COLS*8-1:0] iCHARS,
    output logic [7:0]             oLCD_DATA,
    output logic                   oLCD_RS,
    output logic                   oLCD_START,
    input  logic                   iLCD_DONE,
    output logic                   oBUSY,
    output logic                   oFRAME_DONE
);

    localparam int NCH = ROWS * COLS;
    localparam int CCW = $clog2(COLS);
    localparam int IW  = $clog2(NCH);

    lcd_state_t         state_reg, state_next;
    logic [1:0]         init_idx_reg, init_idx_next;
    logic               init_done_reg, init_done_next;
    logic               row_reg, row_next;
    logic [CCW-1:0]     col_reg, col_next;
    logic               row_cmd_reg, row_cmd_next;   // next transfer is the row address
    logic               frame_done_reg, frame_done_next;
    logic [7:0]         data_reg, data_next;
    logic               rs_reg, rs_next;
    logic               start_reg;
    logic [NCH*8-1:0]   snap_reg;
    logic               snap_load;
    logic               tmr_load, tmr_count, tmr_expired;
    logic [7:0]         char_arr [NCH];
    logic [IW-1:0]      char_idx;

    // Sanitised view of every snapshot byte.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_char
            assign char_arr[gi] = lcd_printable(snap_reg[gi*8 +: 8]);
        end
    endgenerate

    lcd_settle_timer #(
        .DLY_CYCLES (DLY_CYCLES)
    ) u_settle (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .load    (tmr_load),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    // Next-state logic: transfer handshake, settle wait and index walking.
    always_comb begin
        state_next      = state_reg;
        init_idx_next   = init_idx_reg;
        init_done_next  = init_done_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        row_cmd_next    = row_cmd_reg;
        frame_done_next = 1'b0;
        snap_load       = 1'b0;
        tmr_load        = 1'b0;
        tmr_count       = 1'b0;
        case (state_reg)
            INIT:    state_next = ISSUE;
            LATCH: begin
                snap_load  = 1'b1;
                state_next = ISSUE;
            end
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (iLCD_DONE) state_next = SETTLE;
            end
            SETTLE: begin
                tmr_count = 1'b1;
                if (tmr_expired) begin
                    tmr_load   = 1'b1;
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                if (!init_done_reg) begin
                    if (init_idx_reg == 2'd3) begin
                        init_done_next = 1'b1;
                        state_next     = LATCH;
                    end else begin
                        init_idx_next = init_idx_reg + 2'd1;
                        state_next    = INIT;
                    end
                end else if (row_cmd_reg) begin
                    row_cmd_next = 1'b0;
                    state_next   = ISSUE;
                end else if (col_reg == CCW'(COLS - 1)) begin
                    col_next     = '0;
                    row_cmd_next = 1'b1;
                    if (row_reg == 1'(ROWS - 1)) begin
                        row_next        = 1'b0;
                        frame_done_next = 1'b1;
`ifdef LCD_REFRESH_ON_CHANGE_EN
                        state_next      = IDLE;
`else
                        state_next      = LATCH;
`endif
                    end else begin
                        row_next   = row_reg + 1'b1;
                        state_next = ISSUE;
                    end
                end else begin
                    col_next   = col_reg + CCW'(1);
                    state_next = ISSUE;
                end
            end
`ifdef LCD_REFRESH_ON_CHANGE_EN
            IDLE: begin
                if (iCHARS != snap_reg) state_next = LATCH;
            end
`endif
            default: state_next = INIT;
        endcase
    end

    // Byte for the upcoming transfer, chosen from the indices it will use.
    always_comb begin
        char_idx = IW'(col_next);
        if (row_next) char_idx = IW'(col_next) + IW'(COLS);
        data_next = 8'h00;
        rs_next   = 1'b0;
        if (!init_done_next) begin
            case (init_idx_next)
                2'd0:    data_next = LCD_CMD_FUNC;
                2'd1:    data_next = LCD_CMD_DISP;
                2'd2:    data_next = LCD_CMD_CLR;
                default: data_next = LCD_CMD_ENTRY;
            endcase
        end else if (row_cmd_next) begin
            data_next = LCD_CMD_DDRAM | (row_next ? LCD_ROW1_BASE : 8'h00);
        end else begin
            data_next = char_arr[char_idx];
            rs_next   = 1'b1;
        end
    end

    // State, indices, snapshot and registered LCD-side outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg      <= INIT;
            init_idx_reg   <= '0;
            init_done_reg  <= 1'b0;
            row_reg        <= 1'b0;
            col_reg        <= '0;
            row_cmd_reg    <= 1'b1;
            frame_done_reg <= 1'b0;
            data_reg       <= 8'h00;
            rs_reg         <= 1'b0;
            start_reg      <= 1'b0;
            snap_reg       <= {NCH{8'h20}};
        end else begin
            state_reg      <= state_next;
            init_idx_reg   <= init_idx_next;
            init_done_reg  <= init_done_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            row_cmd_reg    <= row_cmd_next;
            frame_done_reg <= frame_done_next;
            // START spans ISSUE and WAIT; it drops on the edge that sees DONE.
            start_reg      <= (state_next == ISSUE) || (state_next == WAIT);
            if (state_next == ISSUE) begin
                data_reg <= data_next;
                rs_reg   <= rs_next;
            end
            if (snap_load) snap_reg <= iCHARS;
        end
    end

`ifdef LCD_REFRESH_ON_CHANGE_EN
    logic busy_reg;

    // Busy everywhere except the parked IDLE state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) busy_reg <= 1'b1;
        else         busy_reg <= (state_next != IDLE);
    end

    assign oBUSY = busy_reg;
`else
    assign oBUSY = 1'b1;
`endif

    assign oLCD_DATA   = data_reg;
    assign oLCD_RS     = rs_reg;
    assign oLCD_START  = start_reg;
    assign oFRAME_DONE = frame_done_reg;

endmodule
